fetch_stage: RTL and testbench

Instruction-fetch stage of the RISC-V pipeline. It holds the program counter, drives the byte address of the combinational, byte-addressed instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register. Decode consumes IF/ID; execute/branch logic feeds back stall, flush and redirect requests.

---
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage. Holds the PC, presents it as the byte address of a
//   combinational instruction memory and captures the returned word into the
//   IF/ID register. Redirect, stall and flush come back from later stages.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   stall_i               hold PC and IF/ID
//   flush_i               squash IF/ID to a bubble
//   redirect_i            load redirect_pc_i (word-aligned) into the PC
//   redirect_pc_i         redirect target byte address
//   imem_addr_o           instruction memory byte address (== PC register)
//   imem_data_i           instruction word at imem_addr_o, same cycle
//   if_id_inst_o          registered instruction
//   if_id_pc_o/pc4_o      registered PC and PC+4 of that instruction
//   if_id_valid_o         IF/ID holds a real instruction
//   misalign_o            sticky: some redirect target had nonzero low bits
//   fetch_count_o         number of valid instructions loaded into IF/ID
module fetch_stage #(
  parameter int unsigned             ADDR_W   = 7,
  parameter int unsigned             BITS     = 32,
  parameter logic [ADDR_W-1:0]       RESET_PC = '0,
  parameter logic [BITS-1:0]         NOP      = BITS'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [BITS-1:0]   imem_data_i,
  output logic [BITS-1:0]   if_id_inst_o,
  output logic [ADDR_W-1:0] if_id_pc_o,
  output logic [ADDR_W-1:0] if_id_pc4_o,
  output logic              if_id_valid_o,
  output logic              misalign_o,
  output logic [31:0]       fetch_count_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [BITS-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic [ADDR_W-1:0] ifpc4_q, ifpc4_d;
  logic              valid_q, valid_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       count_q, count_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic              bubble;

  // Truncation to ADDR_W gives the wrap from the top word back to 0.
  assign pc_plus4 = pc_q + ADDR_W'(4);
  // A redirect squashes the wrong-path word fetched this cycle.
  assign bubble   = redirect_i | flush_i;

  always_comb begin
    pc_d       = pc_q;
    inst_d     = inst_q;
    ifpc_d     = ifpc_q;
    ifpc4_d    = ifpc4_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    count_d    = count_q;

    if (redirect_i) begin
      pc_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
      if (redirect_pc_i[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (!stall_i) begin
      pc_d = pc_plus4;
    end

    if (bubble) begin
      inst_d  = NOP;
      ifpc_d  = pc_q;
      ifpc4_d = pc_plus4;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      inst_d  = imem_data_i;
      ifpc_d  = pc_q;
      ifpc4_d = pc_plus4;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      inst_q     <= NOP;
      ifpc_q     <= '0;
      ifpc4_q    <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      ifpc_q     <= ifpc_d;
      ifpc4_q    <= ifpc4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign if_id_inst_o  = inst_q;
  assign if_id_pc_o    = ifpc_q;
  assign if_id_pc4_o   = ifpc4_q;
  assign if_id_valid_o = valid_q;
  assign misalign_o    = misalign_q;
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios with literal expectations,
// a random phase, and a behavioural model compared on every falling edge.
module tb_fetch_stage;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall_i, flush_i, redirect_i;
  logic [AW-1:0] redirect_pc_i;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_data_i;
  logic [31:0]   if_id_inst_o;
  logic [AW-1:0] if_id_pc_o, if_id_pc4_o;
  logic          if_id_valid_o, misalign_o;
  logic [31:0]   fetch_count_o;

  logic [31:0] mem [0:31];

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .if_id_inst_o(if_id_inst_o), .if_id_pc_o(if_id_pc_o),
    .if_id_pc4_o(if_id_pc4_o), .if_id_valid_o(if_id_valid_o),
    .misalign_o(misalign_o), .fetch_count_o(fetch_count_o)
  );

  always #5 clk = ~clk;

  assign imem_data_i = mem[imem_addr_o[AW-1:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: byte addresses as plain integers modulo 128.
  int          m_pc = 0;
  logic [31:0] m_inst = 32'h13;
  int          m_ifpc = 0, m_ifpc4 = 0;
  bit          m_valid = 0, m_mis = 0;
  logic [31:0] m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 0; m_inst <= 32'h13; m_ifpc <= 0; m_ifpc4 <= 0;
      m_valid <= 0; m_mis <= 0; m_cnt <= 0;
    end else begin
      if (redirect_i || flush_i) begin
        m_inst <= 32'h13; m_valid <= 0;
        m_ifpc <= m_pc; m_ifpc4 <= (m_pc + 4) % 128;
      end else if (!stall_i) begin
        m_inst <= mem[m_pc / 4]; m_valid <= 1;
        m_ifpc <= m_pc; m_ifpc4 <= (m_pc + 4) % 128;
        m_cnt <= m_cnt + 1;
      end
      if (redirect_i) begin
        m_pc <= int'(redirect_pc_i) - (int'(redirect_pc_i) % 4);
        if (int'(redirect_pc_i) % 4 != 0) m_mis <= 1;
      end else if (!stall_i) begin
        m_pc <= (m_pc + 4) % 128;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_addr",  32'(imem_addr_o),   32'(m_pc));
      chk("m_inst",  if_id_inst_o,       m_inst);
      chk("m_pc",    32'(if_id_pc_o),    32'(m_ifpc));
      chk("m_pc4",   32'(if_id_pc4_o),   32'(m_ifpc4));
      chk("m_valid", 32'(if_id_valid_o), 32'(m_valid));
      chk("m_mis",   32'(misalign_o),    32'(m_mis));
      chk("m_cnt",   fetch_count_o,      m_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input bit s, input bit f, input bit r, input logic [AW-1:0] t);
    stall_i = s; flush_i = f; redirect_i = r; redirect_pc_i = t;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, '0);
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h11111111; mem[1] = 32'h22222222; mem[2] = 32'h33333333;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // Reset release and first three fetches
    rst_n = 1'b1;
    #1 chk("rst_addr", 32'(imem_addr_o), 32'h0);
    chk("rst_valid", 32'(if_id_valid_o), 32'h0);
    cyc(); chk("e1_inst", if_id_inst_o, 32'h11111111); chk("e1_pc", 32'(if_id_pc_o), 32'h0);
           chk("e1_valid", 32'(if_id_valid_o), 32'h1);
    cyc(); chk("e2_inst", if_id_inst_o, 32'h22222222); chk("e2_pc", 32'(if_id_pc_o), 32'h4);
    cyc(); chk("e3_inst", if_id_inst_o, 32'h33333333); chk("e3_pc", 32'(if_id_pc_o), 32'h8);
           chk("e3_cnt", fetch_count_o, 32'd3);

    // Stall two cycles at pc=8
    rst_n = 1'b0; #1 rst_n = 1'b1;
    cyc(); cyc();
    chk("st_pre_addr", 32'(imem_addr_o), 32'h8);
    set_in(1, 0, 0, '0);
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("st_addr", 32'(imem_addr_o), 32'h8);
      chk("st_inst", if_id_inst_o, 32'h22222222);
      chk("st_cnt", fetch_count_o, 32'd2);
    end
    set_in(0, 0, 0, '0);
    cyc(); chk("st_rel_inst", if_id_inst_o, 32'h33333333); chk("st_rel_cnt", fetch_count_o, 32'd3);

    // Redirect to 0x40 from pc=0x0C
    chk("rd_pre_addr", 32'(imem_addr_o), 32'h0C);
    set_in(0, 0, 1, 7'h40);
    cyc(); chk("rd_valid", 32'(if_id_valid_o), 32'h0); chk("rd_inst", if_id_inst_o, 32'h13);
           chk("rd_addr", 32'(imem_addr_o), 32'h40);
    set_in(0, 0, 0, '0);
    cyc(); chk("rd_tgt_inst", if_id_inst_o, mem[16]); chk("rd_tgt_pc", 32'(if_id_pc_o), 32'h40);
           chk("rd_tgt_pc4", 32'(if_id_pc4_o), 32'h44); chk("rd_tgt_valid", 32'(if_id_valid_o), 32'h1);

    // Redirect + stall + flush together
    set_in(1, 1, 1, 7'h20);
    cyc(); chk("rsf_addr", 32'(imem_addr_o), 32'h20); chk("rsf_valid", 32'(if_id_valid_o), 32'h0);
    // Flush + stall at pc=0x10
    set_in(0, 0, 1, 7'h10);
    cyc();
    set_in(1, 1, 0, '0);
    cyc(); chk("fs_addr", 32'(imem_addr_o), 32'h10); chk("fs_valid", 32'(if_id_valid_o), 32'h0);
           chk("fs_inst", if_id_inst_o, 32'h13);

    // Misaligned redirect and wrap
    set_in(0, 0, 1, 7'h7E);
    cyc(); chk("mis_addr", 32'(imem_addr_o), 32'h7C); chk("mis_flag", 32'(misalign_o), 32'h1);
    set_in(0, 0, 0, '0);
    cyc(); chk("wrap_addr", 32'(imem_addr_o), 32'h0); chk("wrap_pc4", 32'(if_id_pc4_o), 32'h0);
           chk("wrap_inst", if_id_inst_o, mem[31]);

    // Random phase; flag stays sticky throughout
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 8) == 0, 7'($urandom));
      cyc();
    end
    chk("mis_sticky", 32'(misalign_o), 32'h1);

    // Asynchronous reset between edges while a redirect is pending
    set_in(0, 0, 1, 7'h55);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("ar_addr",  32'(imem_addr_o),   32'h0);
    chk("ar_inst",  if_id_inst_o,       32'h13);
    chk("ar_pc",    32'(if_id_pc_o),    32'h0);
    chk("ar_pc4",   32'(if_id_pc4_o),   32'h0);
    chk("ar_valid", 32'(if_id_valid_o), 32'h0);
    chk("ar_mis",   32'(misalign_o),    32'h0);
    chk("ar_cnt",   fetch_count_o,      32'h0);
    set_in(0, 0, 0, '0);
    @(negedge clk); rst_n = 1'b1;
    cyc(); chk("ar_restart_inst", if_id_inst_o, 32'h11111111); chk("ar_restart_pc", 32'(if_id_pc_o), 32'h0);

    for (int i = 0; i < 200; i++) begin
      set_in(($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 10) == 0, 7'($urandom));
      cyc();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
